// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// BCD MM:SS countdown timer for the microwave controller. Keypad digits are
// shifted into the preset while idle. Once started with the door closed, the
// preset counts down one second every TICKS_PER_SEC clock cycles. Counting
// pauses on door-open or the pause command, and the timer flags completion
// when it reaches 00:00.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per counted second (must be >= 2)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   key_valid    in   one-cycle strobe, key_digit carries a new digit
//   key_digit    in   [3:0] keypad digit, BCD 0-9 (10-15 ignored)
//   start        in   start / resume command (level)
//   pause        in   pause command (level)
//   clear        in   clear / cancel command (level)
//   door_closed  in   1 = door closed, required for counting
//   min_out      out  [3:0] minutes digit, BCD
//   dseg_out     out  [3:0] tens-of-seconds digit, BCD
//   seg_out      out  [3:0] units-of-seconds digit, BCD
//   running      out  1 while counting (RUN)
//   done         out  1 after reaching 00:00 (DONE)
// -----------------------------------------------------------------------------
module countdown_timer #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   input  logic       door_closed,
   output logic [3:0] min_out,
   output logic [3:0] dseg_out,
   output logic [3:0] seg_out,
   output logic       running,
   output logic       done
);

   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TERM_COUNT = PW'(TICKS_PER_SEC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [3:0]    r_min;
   logic [3:0]    r_dseg;
   logic [3:0]    r_seg;
   logic          r_running;
   logic          r_done;

   logic [3:0]    w_dec_min;
   logic [3:0]    w_dec_dseg;
   logic [3:0]    w_dec_seg;
   logic          w_dec_zero;
   logic          w_time_zero;
   logic          w_tick;
   logic          w_key_ok;
   logic          w_can_start;

   // One-second decrement with BCD borrow. dseg is treated as a plain digit
   // (may hold 6-9 after entry); a borrow out of it always reloads 5.
   always_comb begin
      w_dec_min  = r_min;
      w_dec_dseg = r_dseg;
      w_dec_seg  = r_seg;
      if (r_seg != 4'd0) begin
         w_dec_seg = r_seg - 4'd1;
      end else begin
         w_dec_seg = 4'd9;
         if (r_dseg != 4'd0) begin
            w_dec_dseg = r_dseg - 4'd1;
         end else begin
            w_dec_dseg = 4'd5;
            w_dec_min  = r_min - 4'd1;
         end
      end
   end

   assign w_dec_zero  = (w_dec_min == 4'd0) && (w_dec_dseg == 4'd0) && (w_dec_seg == 4'd0);
   assign w_time_zero = (r_min == 4'd0) && (r_dseg == 4'd0) && (r_seg == 4'd0);
   assign w_tick      = (r_presc == TERM_COUNT);
   assign w_key_ok    = key_valid && (key_digit <= 4'd9);
   assign w_can_start = start && door_closed && !w_time_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_presc   <= '0;
         r_min     <= 4'd0;
         r_dseg    <= 4'd0;
         r_seg     <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else if (clear) begin
         // Cancel from any state.
         r_state   <= ST_IDLE;
         r_presc   <= '0;
         r_min     <= 4'd0;
         r_dseg    <= 4'd0;
         r_seg     <= 4'd0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_can_start) begin
                  r_state   <= ST_RUN;
                  r_presc   <= '0;
                  r_running <= 1'b1;
               end else if (!start && !pause && w_key_ok) begin
                  // Keys only land when no command is competing this cycle.
                  r_min  <= r_dseg;
                  r_dseg <= r_seg;
                  r_seg  <= key_digit;
               end
            end

            ST_RUN: begin
               // Door-open / pause beat the terminal count: no decrement
               // happens on the edge that enters PAUSED, prescaler is held.
               if (!door_closed || pause) begin
                  r_state   <= ST_PAUSED;
                  r_running <= 1'b0;
               end else if (w_tick) begin
                  r_presc <= '0;
                  r_min   <= w_dec_min;
                  r_dseg  <= w_dec_dseg;
                  r_seg   <= w_dec_seg;
                  if (w_dec_zero) begin
                     r_state   <= ST_DONE;
                     r_running <= 1'b0;
                     r_done    <= 1'b1;
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end

            ST_PAUSED: begin
               // Resume keeps the partially elapsed second.
               if (start && door_closed) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end
            end

            ST_DONE: begin
               // Held at 00:00 until clear.
            end

            default: begin
               r_state   <= ST_IDLE;
               r_running <= 1'b0;
               r_done    <= 1'b0;
            end
         endcase
      end
   end

   assign min_out  = r_min;
   assign dseg_out = r_dseg;
   assign seg_out  = r_seg;
   assign running  = r_running;
   assign done     = r_done;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Table-driven bench for countdown_timer with TICKS_PER_SEC = 4. Each record
// holds one cycle of inputs plus the outputs expected after that edge; the
// expectation is queued when the stimulus is driven and popped once the DUT
// has produced its registered outputs. Pause/resume, terminal-count conflicts
// and mid-count reset are covered by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

   localparam int TPS = 4;

   logic       clk;
   logic       rst_n;
   logic       key_valid;
   logic [3:0] key_digit;
   logic       start;
   logic       pause;
   logic       clear;
   logic       door_closed;
   logic [3:0] min_out;
   logic [3:0] dseg_out;
   logic [3:0] seg_out;
   logic       running;
   logic       done;

   countdown_timer #(.TICKS_PER_SEC(TPS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .key_digit   (key_digit),
      .start       (start),
      .pause       (pause),
      .clear       (clear),
      .door_closed (door_closed),
      .min_out     (min_out),
      .dseg_out    (dseg_out),
      .seg_out     (seg_out),
      .running     (running),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       kv;
      logic [3:0] kd;
      logic       st;
      logic       pa;
      logic       cl;
      logic       dc;
      logic [3:0] emin;
      logic [3:0] edseg;
      logic [3:0] eseg;
      logic       erun;
      logic       edone;
   } vec_t;

   vec_t        vecs[$];
   logic [13:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          txn      = 0;

   task automatic add(input logic kv, input logic [3:0] kd, input logic st,
                      input logic pa, input logic cl, input logic dc,
                      input logic [3:0] emin, input logic [3:0] edseg,
                      input logic [3:0] eseg, input logic erun, input logic edone);
      vec_t v;
      v.kv = kv; v.kd = kd; v.st = st; v.pa = pa; v.cl = cl; v.dc = dc;
      v.emin = emin; v.edseg = edseg; v.eseg = eseg; v.erun = erun; v.edone = edone;
      vecs.push_back(v);
   endtask

   task automatic compare(input string name, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      txn++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h:%h%h run=%b done=%b, want %h:%h%h run=%b done=%b",
                  name, got[13:10], got[9:6], got[5:2], got[1], got[0],
                  exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
      end else begin
         $display("txn %0d %s: %h:%h%h run=%b done=%b", txn, name,
                  got[13:10], got[9:6], got[5:2], got[1], got[0]);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, then check after the edge.
   task automatic apply(input string name, input vec_t v);
      logic [13:0] exp;
      key_valid   = v.kv;
      key_digit   = v.kd;
      start       = v.st;
      pause       = v.pa;
      clear       = v.cl;
      door_closed = v.dc;
      exp_q.push_back({v.emin, v.edseg, v.eseg, v.erun, v.edone});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty: got no entry, want one");
      end else begin
         exp = exp_q.pop_front();
         compare(name, {min_out, dseg_out, seg_out, running, done}, exp);
      end
   endtask

   // Shorthand for hand-written steps.
   task automatic step(input string name, input logic kv, input logic [3:0] kd,
                       input logic st, input logic pa, input logic cl, input logic dc,
                       input logic [3:0] emin, input logic [3:0] edseg,
                       input logic [3:0] eseg, input logic erun, input logic edone);
      vec_t v;
      v.kv = kv; v.kd = kd; v.st = st; v.pa = pa; v.cl = cl; v.dc = dc;
      v.emin = emin; v.edseg = edseg; v.eseg = eseg; v.erun = erun; v.edone = edone;
      apply(name, v);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n       = 1'b0;
      key_valid   = 1'b0;
      key_digit   = 4'd0;
      start       = 1'b0;
      pause       = 1'b0;
      clear       = 1'b0;
      door_closed = 1'b1;

      // Table: kv kd st pa cl dc | min dseg seg run done
      add(1, 1, 0,0,0,1, 0,0,1, 0,0);   // key 1
      add(1, 3, 0,0,0,1, 0,1,3, 0,0);   // key 3
      add(1, 0, 0,0,0,1, 1,3,0, 0,0);   // key 0 -> 1:30
      add(1,12, 0,0,0,1, 1,3,0, 0,0);   // key 12 ignored
      add(0, 0, 0,0,0,1, 1,3,0, 0,0);
      add(0, 0, 0,0,1,1, 0,0,0, 0,0);   // clear in IDLE
      add(1, 2, 0,0,0,1, 0,0,2, 0,0);   // preset 0:02
      add(0, 0, 1,0,0,1, 0,0,2, 1,0);   // start
      add(0, 0, 0,0,0,1, 0,0,2, 1,0);
      add(0, 0, 0,0,0,1, 0,0,2, 1,0);
      add(0, 0, 0,0,0,1, 0,0,2, 1,0);
      add(0, 0, 0,0,0,1, 0,0,1, 1,0);   // 4 cycles -> 0:01
      add(0, 0, 0,0,0,1, 0,0,1, 1,0);
      add(0, 0, 0,0,0,1, 0,0,1, 1,0);
      add(0, 0, 0,0,0,1, 0,0,1, 1,0);
      add(0, 0, 0,0,0,1, 0,0,0, 0,1);   // 8 cycles -> DONE
      add(0, 0, 1,0,0,1, 0,0,0, 0,1);   // start ignored in DONE
      add(1, 5, 0,0,0,1, 0,0,0, 0,1);   // key ignored in DONE
      add(0, 0, 0,1,0,1, 0,0,0, 0,1);   // pause ignored in DONE
      add(0, 0, 0,0,1,1, 0,0,0, 0,0);   // clear in DONE
      add(0, 0, 1,0,0,1, 0,0,0, 0,0);   // start at 00:00 stays IDLE
      add(1, 1, 0,0,0,1, 0,0,1, 0,0);
      add(1, 0, 0,0,0,1, 0,1,0, 0,0);
      add(1, 0, 0,0,0,1, 1,0,0, 0,0);   // 1:00
      add(0, 0, 1,0,0,1, 1,0,0, 1,0);
      add(0, 0, 0,0,0,1, 1,0,0, 1,0);
      add(0, 0, 0,0,0,1, 1,0,0, 1,0);
      add(0, 0, 0,0,0,1, 1,0,0, 1,0);
      add(0, 0, 0,0,0,1, 0,5,9, 1,0);   // 1:00 -> 0:59
      add(0, 0, 0,0,1,1, 0,0,0, 0,0);
      add(1, 1, 0,0,0,1, 0,0,1, 0,0);
      add(1, 0, 0,0,0,1, 0,1,0, 0,0);   // 0:10
      add(0, 0, 1,0,0,1, 0,1,0, 1,0);
      add(1, 7, 0,0,0,1, 0,1,0, 1,0);   // key ignored in RUN
      add(0, 0, 0,0,0,1, 0,1,0, 1,0);
      add(0, 0, 0,0,0,1, 0,1,0, 1,0);
      add(0, 0, 0,0,0,1, 0,0,9, 1,0);   // 0:10 -> 0:09
      add(0, 0, 0,0,1,1, 0,0,0, 0,0);   // clear in RUN
      add(1, 5, 0,0,0,1, 0,0,5, 0,0);   // 0:05
      add(0, 0, 1,0,0,0, 0,0,5, 0,0);   // start with door open: no effect
      add(0, 0, 0,0,0,0, 0,0,5, 0,0);

      #12;
      compare("reset_state", {min_out, dseg_out, seg_out, running, done}, 14'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply($sformatf("vec%0d", i), vecs[i]);
      end

      // Pause mid-second by door-open, resume keeps the prescaler phase.
      step("run_005",       0,0, 1,0,0,1, 0,0,5, 1,0);   // p=0
      step("run_p1",        0,0, 0,0,0,1, 0,0,5, 1,0);   // p=1
      step("run_p2",        0,0, 0,0,0,1, 0,0,5, 1,0);   // p=2
      step("door_open",     0,0, 0,0,0,0, 0,0,5, 0,0);   // PAUSED, p held 2
      for (int k = 0; k < 10; k++) begin
         step($sformatf("door_held%0d", k), 0,0, 0,0,0,0, 0,0,5, 0,0);
      end
      step("door_closed",   0,0, 0,0,0,1, 0,0,5, 0,0);   // still PAUSED
      step("resume",        0,0, 1,0,0,1, 0,0,5, 1,0);   // p=2
      step("resume_p3",     0,0, 0,0,0,1, 0,0,5, 1,0);   // p=3
      step("resume_dec",    0,0, 0,0,0,1, 0,0,4, 1,0);   // 2 cycles later
      step("run_a",         0,0, 0,0,0,1, 0,0,4, 1,0);
      step("run_b",         0,0, 0,0,0,1, 0,0,4, 1,0);
      step("run_c",         0,0, 0,0,0,1, 0,0,4, 1,0);   // p=3
      step("door_at_tc",    0,0, 0,0,0,0, 0,0,4, 0,0);   // no decrement
      step("resume_at_tc",  0,0, 1,0,0,1, 0,0,4, 1,0);   // p still 3
      step("tc_dec",        0,0, 0,0,0,1, 0,0,3, 1,0);
      step("start_pause",   0,0, 1,1,0,1, 0,0,3, 0,0);   // PAUSED
      step("pause_held",    0,0, 0,1,0,1, 0,0,3, 0,0);
      step("clear_paused",  0,0, 0,0,1,1, 0,0,0, 0,0);

      // Asynchronous reset mid-count at 0:37.
      step("key3",          1,3, 0,0,0,1, 0,0,3, 0,0);
      step("key7",          1,7, 0,0,0,1, 0,3,7, 0,0);
      step("run_037",       0,0, 1,0,0,1, 0,3,7, 1,0);
      step("run_037a",      0,0, 0,0,0,1, 0,3,7, 1,0);
      step("run_037b",      0,0, 0,0,0,1, 0,3,7, 1,0);
      #2;
      rst_n = 1'b0;
      #1;
      compare("async_reset", {min_out, dseg_out, seg_out, running, done}, 14'd0);
      #1;
      rst_n = 1'b1;
      step("start_after_rst", 0,0, 1,0,0,1, 0,0,0, 0,0);

      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
